// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR controller. One signed multiplier
// and one accumulator are shared across 2..6 taps, one tap per clock.
// Samples enter on a valid/ready handshake; results leave on a valid/ready
// handshake. Holds the writable coefficient bank and the sample delay line.
// Optional build macro: FIR_SEQ_SAT_EN saturates the accumulator to the
// signed 2*width range on outData; without it outData wraps (low bits).
module fir_mac_sequencer #(
   parameter int width    = 16,
   parameter int MAX_TAPS = 6
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic signed [width-1:0]   inData,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [2:0]                tap_control,
   input  logic                      coef_we,
   input  logic [2:0]                coef_addr,
   input  logic signed [width-1:0]   coef_data,
   output logic                      coef_busy,
   output logic signed [2*width-1:0] outData,
   output logic                      out_valid,
   input  logic                      out_ready
);

   localparam int PROD_W = 2 * width;
   localparam int ACC_W  = 2 * width + 3;

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                   state_reg, state_next;
   logic signed [width-1:0]  x_reg [MAX_TAPS];
   logic signed [width-1:0]  c_reg [MAX_TAPS];
   logic signed [ACC_W-1:0]  acc_reg;
   logic [2:0]               k_reg;
   logic [2:0]               n_reg;
   logic [2:0]               n_decoded;
   logic                     accept;
   logic                     coef_wr_en;
   logic                     last_tap;
   logic signed [width-1:0]  tap_x;
   logic signed [width-1:0]  tap_c;
   logic signed [PROD_W-1:0] prod;

   assign accept     = in_valid & in_ready;
   assign coef_wr_en = coef_we & ~coef_busy;
   assign last_tap   = (k_reg == n_reg - 3'd1);
   // Out-of-range tap counts (0, 1, 7) fall back to the minimum of two taps.
   assign n_decoded  = (tap_control >= 3'd2 && tap_control <= 3'd6) ? tap_control : 3'd2;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state and handshake/busy outputs.
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      coef_busy  = 1'b1;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready  = 1'b1;
            coef_busy = 1'b0;
            if (in_valid) state_next = MAC;
         end
         MAC: begin
            if (last_tap) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            // Output handshake only; a waiting input is taken once back in IDLE.
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < MAX_TAPS; gi++) begin : g_taps
         // Delay line stage: shifts only when a sample is accepted.
         if (gi == 0) begin : g_head
            always_ff @(posedge clk or negedge reset) begin
               if (!reset)      x_reg[gi] <= '0;
               else if (accept) x_reg[gi] <= inData;
            end
         end else begin : g_body
            always_ff @(posedge clk or negedge reset) begin
               if (!reset)      x_reg[gi] <= '0;
               else if (accept) x_reg[gi] <= x_reg[gi-1];
            end
         end

         // Coefficient entry: resets to MAX_TAPS-gi, writable only in IDLE.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)
               c_reg[gi] <= width'(MAX_TAPS - gi);
            else if (coef_wr_en && coef_addr == 3'(gi))
               c_reg[gi] <= coef_data;
         end
      end
   endgenerate

   // Select the current tap's coefficient and sample for the shared multiplier.
   always_comb begin
      tap_x = '0;
      tap_c = '0;
      for (int i = 0; i < MAX_TAPS; i++) begin
         if (k_reg == 3'(i)) begin
            tap_x = x_reg[i];
            tap_c = c_reg[i];
         end
      end
   end

   assign prod = PROD_W'(tap_c) * PROD_W'(tap_x);

   // Accumulator, tap index and latched tap count for the sample in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_reg <= '0;
         k_reg   <= '0;
         n_reg   <= 3'd2;
      end else if (accept) begin
         acc_reg <= '0;
         k_reg   <= '0;
         n_reg   <= n_decoded;
      end else if (state_reg == MAC) begin
         acc_reg <= acc_reg + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
         k_reg   <= k_reg + 3'd1;
      end
   end

   // Reduce the wide accumulator to the output width.
   always_comb begin
      outData = acc_reg[PROD_W-1:0];
`ifdef FIR_SEQ_SAT_EN
      if (!((&acc_reg[ACC_W-1:PROD_W-1]) | ~(|acc_reg[ACC_W-1:PROD_W-1]))) begin
         if (acc_reg[ACC_W-1]) outData = {1'b1, {(PROD_W-1){1'b0}}};
         else                  outData = {1'b0, {(PROD_W-1){1'b1}}};
      end
`endif
   end

endmodule
